// File: rtl/decode_issue_stage_pkg.sv
// Shared constants, instruction field layout and issue payload for the decode/issue stage.
package decode_issue_stage_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 4;
  localparam int unsigned OPC_W   = 4;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned NREG    = 2 ** ADDR_W;

  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 0;

  localparam logic [OPC_W-1:0] NOP_OPCODE   = 4'h0;
  localparam logic [OPC_W-1:0] STORE_OPCODE = 4'hF;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } issue_t;

  // True when the opcode produces a register result.
  function automatic logic op_writes(input logic [OPC_W-1:0] opcode);
    return (opcode != NOP_OPCODE) && (opcode != STORE_OPCODE);
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Instruction, register-file, issue and writeback signals of the decode/issue stage.
interface decode_issue_stage_if;
  import decode_issue_stage_pkg::*;

  logic                instrValid;
  logic [INSTR_W-1:0]  instr;
  logic                instrReady;
  logic [ADDR_W-1:0]   read1;
  logic [ADDR_W-1:0]   read2;
  logic [DATA_W-1:0]   dataRead1;
  logic [DATA_W-1:0]   dataRead2;
  logic                issueValid;
  logic                issueReady;
  logic [OPC_W-1:0]    issueOpcode;
  logic [ADDR_W-1:0]   issueDest;
  logic [DATA_W-1:0]   issueA;
  logic [DATA_W-1:0]   issueB;
  logic                wbValid;
  logic [ADDR_W-1:0]   wbDest;
  logic [STALL_W-1:0]  stallCount;

  modport slave (
    input  instrValid, instr, dataRead1, dataRead2, issueReady, wbValid, wbDest,
    output instrReady, read1, read2, issueValid, issueOpcode, issueDest,
           issueA, issueB, stallCount
  );

  modport master (
    output instrValid, instr, dataRead1, dataRead2, issueReady, wbValid, wbDest,
    input  instrReady, read1, read2, issueValid, issueOpcode, issueDest,
           issueA, issueB, stallCount
  );

endinterface

// File: rtl/decode_issue_stage_reg_scoreboard.sv
// Per-register busy bits: set on issue of a writer, cleared on writeback, queried for hazards.
module decode_issue_stage_reg_scoreboard
  import decode_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              set_i,
  input  logic [ADDR_W-1:0] set_addr_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              rd_chk_i,
  output logic              hazard_c_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_mask_c;
  logic [NREG-1:0] clr_mask_c;

  assign set_mask_c = set_i ? (NREG'(1) << set_addr_i) : '0;
  assign clr_mask_c = clr_i ? (NREG'(1) << clr_addr_i) : '0;

  // Set is applied after clear so a same-edge set/clear leaves the bit busy.
  always_comb begin
    busy_d = (busy_q & ~clr_mask_c) | set_mask_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Uses the registered bits only, so a writeback never bypasses a hazard in its own cycle.
  assign hazard_c_o = busy_q[rs1_i] | busy_q[rs2_i] | (rd_chk_i & busy_q[rd_i]);

endmodule

// File: rtl/decode_issue_stage.sv
// Decodes an instruction, reads operands from the register file and issues into a
// one-entry issue register, stalling on RAW/WAW hazards tracked by the scoreboard.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  decode_issue_stage_if.slave   bus
);

  logic [OPC_W-1:0]   opcode_c;
  logic [ADDR_W-1:0]  rd_c;
  logic [ADDR_W-1:0]  rs1_c;
  logic [ADDR_W-1:0]  rs2_c;
  logic               writes_c;
  logic               hazard_c;
  logic               slot_free_c;
  logic               instr_ready_c;
  logic               accept_c;

  issue_t             issue_q;
  issue_t             issue_d;
  logic               issue_valid_q;
  logic               issue_valid_d;
  logic [STALL_W-1:0] stall_q;
  logic [STALL_W-1:0] stall_d;

  assign opcode_c = bus.instr[OPC_LSB +: OPC_W];
  assign rd_c     = bus.instr[RD_LSB  +: ADDR_W];
  assign rs1_c    = bus.instr[RS1_LSB +: ADDR_W];
  assign rs2_c    = bus.instr[RS2_LSB +: ADDR_W];
  assign writes_c = op_writes(opcode_c);

  decode_issue_stage_reg_scoreboard u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_i      (accept_c & writes_c),
    .set_addr_i (rd_c),
    .clr_i      (bus.wbValid),
    .clr_addr_i (bus.wbDest),
    .rs1_i      (rs1_c),
    .rs2_i      (rs2_c),
    .rd_i       (rd_c),
    .rd_chk_i   (writes_c),
    .hazard_c_o (hazard_c)
  );

  assign slot_free_c   = !issue_valid_q || bus.issueReady;
  assign instr_ready_c = slot_free_c && !hazard_c;
  assign accept_c      = bus.instrValid && instr_ready_c;

  // Issue register load/drain and saturating stall counter.
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = issue_valid_q;
    stall_d       = stall_q;

    if (accept_c) begin
      issue_d.opcode = opcode_c;
      issue_d.dest   = rd_c;
      issue_d.a      = bus.dataRead1;
      issue_d.b      = bus.dataRead2;
      issue_valid_d  = 1'b1;
    end else if (issue_valid_q && bus.issueReady) begin
      issue_valid_d  = 1'b0;
    end

    if (bus.instrValid && hazard_c && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_q       <= '0;
      issue_valid_q <= 1'b0;
      stall_q       <= '0;
    end else begin
      issue_q       <= issue_d;
      issue_valid_q <= issue_valid_d;
      stall_q       <= stall_d;
    end
  end

  assign bus.instrReady  = instr_ready_c;
  assign bus.read1       = rs1_c;
  assign bus.read2       = rs2_c;
  assign bus.issueValid  = issue_valid_q;
  assign bus.issueOpcode = issue_q.opcode;
  assign bus.issueDest   = issue_q.dest;
  assign bus.issueA      = issue_q.a;
  assign bus.issueB      = issue_q.b;
  assign bus.stallCount  = stall_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: reset, issue, RAW/WAW stalls, backpressure,
// non-writing opcodes, same-edge set/clear and reset during a stall.
module tb_decode_issue_stage;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  decode_issue_stage_if bus ();

  decode_issue_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.instrValid = 1'b0; bus.instr = '0; bus.dataRead1 = '0; bus.dataRead2 = '0;
    bus.issueReady = 1'b0; bus.wbValid = 1'b0; bus.wbDest = '0;
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (bus.issueValid !== 1'b0) begin n_fail++; $display("FAIL reset_issueValid got=%0h exp=0", bus.issueValid); end
    n_cmp++; if (bus.issueOpcode !== 4'h0) begin n_fail++; $display("FAIL reset_issueOpcode got=%0h exp=0", bus.issueOpcode); end
    n_cmp++; if (bus.issueDest !== 4'h0) begin n_fail++; $display("FAIL reset_issueDest got=%0h exp=0", bus.issueDest); end
    n_cmp++; if (bus.issueA !== 16'h0 || bus.issueB !== 16'h0) begin n_fail++; $display("FAIL reset_issueAB got=%0h/%0h exp=0/0", bus.issueA, bus.issueB); end
    n_cmp++; if (bus.stallCount !== 16'h0) begin n_fail++; $display("FAIL reset_stallCount got=%0h exp=0", bus.stallCount); end
    bus.instrValid = 1'b1; bus.instr = 16'h1312;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL reset_instrReady got=%0h exp=1", bus.instrReady); end
    @(negedge clk) reset = 1'b0;
    tick();
    n_cmp++; if (bus.issueValid !== 1'b1) begin n_fail++; $display("FAIL reset_pre_issue got=%0h exp=1", bus.issueValid); end
    bus.instr = 16'h2430;
    tick();
    n_cmp++; if (bus.stallCount !== 16'h1) begin n_fail++; $display("FAIL reset_pre_stall got=%0h exp=1", bus.stallCount); end
    // Reset asserted mid-cycle must take effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.issueValid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_issueValid got=%0h exp=0", bus.issueValid); end
    n_cmp++; if (bus.stallCount !== 16'h0) begin n_fail++; $display("FAIL reset_mid_stallCount got=%0h exp=0", bus.stallCount); end
    n_cmp++; if (bus.issueOpcode !== 4'h0 || bus.issueDest !== 4'h0) begin n_fail++; $display("FAIL reset_mid_fields got=%0h/%0h exp=0/0", bus.issueOpcode, bus.issueDest); end
    bus.instr = 16'h1312;
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL reset_mid_busy_cleared got=%0h exp=1", bus.instrReady); end
    bus.instrValid = 1'b0;
    tick();
  endtask

  task automatic test_issue();
    bus.issueReady = 1'b1;
    bus.instrValid = 1'b1; bus.instr = 16'h1312;
    bus.dataRead1 = 16'h0002; bus.dataRead2 = 16'h0003;
    #1;
    n_cmp++; if (bus.read1 !== 4'h1) begin n_fail++; $display("FAIL issue_read1 got=%0h exp=1", bus.read1); end
    n_cmp++; if (bus.read2 !== 4'h2) begin n_fail++; $display("FAIL issue_read2 got=%0h exp=2", bus.read2); end
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL issue_instrReady got=%0h exp=1", bus.instrReady); end
    tick();
    bus.instrValid = 1'b0;
    n_cmp++; if (bus.issueValid !== 1'b1) begin n_fail++; $display("FAIL issue_issueValid got=%0h exp=1", bus.issueValid); end
    n_cmp++; if (bus.issueOpcode !== 4'h1) begin n_fail++; $display("FAIL issue_opcode got=%0h exp=1", bus.issueOpcode); end
    n_cmp++; if (bus.issueDest !== 4'h3) begin n_fail++; $display("FAIL issue_dest got=%0h exp=3", bus.issueDest); end
    n_cmp++; if (bus.issueA !== 16'h0002) begin n_fail++; $display("FAIL issue_A got=%0h exp=2", bus.issueA); end
    n_cmp++; if (bus.issueB !== 16'h0003) begin n_fail++; $display("FAIL issue_B got=%0h exp=3", bus.issueB); end
  endtask

  task automatic test_raw();
    bus.instrValid = 1'b1; bus.instr = 16'h2430;
    bus.dataRead1 = 16'h0033; bus.dataRead2 = 16'h0044;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL raw_stall got=%0h exp=0", bus.instrReady); end
    tick();
    n_cmp++; if (bus.stallCount !== 16'h1) begin n_fail++; $display("FAIL raw_stall1 got=%0h exp=1", bus.stallCount); end
    n_cmp++; if (bus.issueValid !== 1'b0) begin n_fail++; $display("FAIL raw_drain got=%0h exp=0", bus.issueValid); end
    tick();
    n_cmp++; if (bus.stallCount !== 16'h2) begin n_fail++; $display("FAIL raw_stall2 got=%0h exp=2", bus.stallCount); end
    bus.wbValid = 1'b1; bus.wbDest = 4'h3;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass got=%0h exp=0", bus.instrReady); end
    tick();
    bus.wbValid = 1'b0;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL raw_ready_after_wb got=%0h exp=1", bus.instrReady); end
    n_cmp++; if (bus.stallCount !== 16'h3) begin n_fail++; $display("FAIL raw_stall3 got=%0h exp=3", bus.stallCount); end
    tick();
    bus.instrValid = 1'b0;
    n_cmp++; if (bus.issueValid !== 1'b1 || bus.issueOpcode !== 4'h2 || bus.issueDest !== 4'h4) begin
      n_fail++; $display("FAIL raw_issue got=v%0h op%0h rd%0h exp=v1 op2 rd4", bus.issueValid, bus.issueOpcode, bus.issueDest); end
    n_cmp++; if (bus.issueA !== 16'h0033 || bus.issueB !== 16'h0044) begin n_fail++; $display("FAIL raw_operands got=%0h/%0h exp=33/44", bus.issueA, bus.issueB); end
    n_cmp++; if (bus.stallCount !== 16'h3) begin n_fail++; $display("FAIL raw_stall_hold got=%0h exp=3", bus.stallCount); end
  endtask

  task automatic test_backpressure();
    bus.issueReady = 1'b0;
    bus.instrValid = 1'b1; bus.instr = 16'h1512;
    bus.dataRead1 = 16'h0AAA; bus.dataRead2 = 16'h0BBB;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL bp_ready_%0d got=%0h exp=0", i, bus.instrReady); end
      tick();
      n_cmp++; if (bus.issueValid !== 1'b1 || bus.issueOpcode !== 4'h2 || bus.issueDest !== 4'h4 ||
                   bus.issueA !== 16'h0033 || bus.issueB !== 16'h0044) begin
        n_fail++; $display("FAIL bp_hold_%0d got=v%0h op%0h rd%0h A%0h B%0h exp=v1 op2 rd4 A33 B44", i,
                           bus.issueValid, bus.issueOpcode, bus.issueDest, bus.issueA, bus.issueB); end
      n_cmp++; if (bus.stallCount !== 16'h3) begin n_fail++; $display("FAIL bp_stall_%0d got=%0h exp=3", i, bus.stallCount); end
    end
    bus.instrValid = 1'b0; bus.issueReady = 1'b1;
    tick();
    n_cmp++; if (bus.issueValid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got=%0h exp=0", bus.issueValid); end
    bus.instr = 16'h2140;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL bp_busy4_kept got=%0h exp=0", bus.instrReady); end
    bus.instr = 16'h0050;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL bp_busy5_clear got=%0h exp=1", bus.instrReady); end
    bus.wbValid = 1'b1; bus.wbDest = 4'h4;
    tick();
    bus.wbValid = 1'b0;
  endtask

  task automatic test_non_writing();
    bus.issueReady = 1'b1;
    bus.instrValid = 1'b1; bus.instr = 16'h0512;
    bus.dataRead1 = 16'h1111; bus.dataRead2 = 16'h2222;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL nop_ready got=%0h exp=1", bus.instrReady); end
    tick();
    n_cmp++; if (bus.issueValid !== 1'b1 || bus.issueOpcode !== 4'h0 || bus.issueDest !== 4'h5 || bus.issueA !== 16'h1111 || bus.issueB !== 16'h2222) begin
      n_fail++; $display("FAIL nop_issue got=v%0h op%0h rd%0h A%0h B%0h exp=v1 op0 rd5 A1111 B2222",
                         bus.issueValid, bus.issueOpcode, bus.issueDest, bus.issueA, bus.issueB); end
    bus.instr = 16'hF512; bus.dataRead1 = 16'h3333; bus.dataRead2 = 16'h4444;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL store_ready got=%0h exp=1", bus.instrReady); end
    tick();
    n_cmp++; if (bus.issueOpcode !== 4'hF || bus.issueA !== 16'h3333 || bus.issueB !== 16'h4444) begin
      n_fail++; $display("FAIL store_issue got=op%0h A%0h B%0h exp=opF A3333 B4444", bus.issueOpcode, bus.issueA, bus.issueB); end
    bus.instr = 16'h1650;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL nw_follow_ready got=%0h exp=1", bus.instrReady); end
    tick();
    bus.instrValid = 1'b0;
    n_cmp++; if (bus.issueOpcode !== 4'h1 || bus.issueDest !== 4'h6 || bus.stallCount !== 16'h3) begin
      n_fail++; $display("FAIL nw_follow_issue got=op%0h rd%0h stall%0h exp=op1 rd6 stall3", bus.issueOpcode, bus.issueDest, bus.stallCount); end
    bus.instrValid = 1'b1; bus.instr = 16'h1612;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL waw_stall got=%0h exp=0", bus.instrReady); end
    bus.instr = 16'h0612;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL waw_nop_ignores_rd got=%0h exp=1", bus.instrReady); end
    bus.instr = 16'hF612;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL waw_store_ignores_rd got=%0h exp=1", bus.instrReady); end
    bus.instrValid = 1'b0;
    bus.wbValid = 1'b1; bus.wbDest = 4'h6;
    tick();
    bus.wbValid = 1'b0;
  endtask

  task automatic test_set_wins();
    bus.issueReady = 1'b1;
    bus.instrValid = 1'b1; bus.instr = 16'h1712;
    bus.wbValid = 1'b1; bus.wbDest = 4'h7;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL setwin_ready got=%0h exp=1", bus.instrReady); end
    tick();
    bus.instrValid = 1'b0; bus.wbValid = 1'b0;
    bus.instrValid = 1'b1; bus.instr = 16'h2070;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL setwin_busy7 got=%0h exp=0", bus.instrReady); end
    bus.instrValid = 1'b0;
    bus.wbValid = 1'b1; bus.wbDest = 4'h7;
    tick();
    bus.wbValid = 1'b0;
    bus.instrValid = 1'b1;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL setwin_cleared got=%0h exp=1", bus.instrReady); end
    bus.instrValid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    bus.issueReady = 1'b1;
    bus.instrValid = 1'b1; bus.instr = 16'h1312;
    bus.dataRead1 = 16'h0002; bus.dataRead2 = 16'h0003;
    tick();
    bus.instr = 16'h2430; bus.dataRead1 = 16'h0055; bus.dataRead2 = 16'h0066;
    tick();
    tick();
    n_cmp++; if (bus.stallCount !== 16'h5) begin n_fail++; $display("FAIL rms_stall got=%0h exp=5", bus.stallCount); end
    n_cmp++; if (bus.instrReady !== 1'b0) begin n_fail++; $display("FAIL rms_stalled got=%0h exp=0", bus.instrReady); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (bus.stallCount !== 16'h0 || bus.issueValid !== 1'b0) begin
      n_fail++; $display("FAIL rms_reset got=stall%0h v%0h exp=stall0 v0", bus.stallCount, bus.issueValid); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if (bus.instrReady !== 1'b1) begin n_fail++; $display("FAIL rms_ready got=%0h exp=1", bus.instrReady); end
    tick();
    bus.instrValid = 1'b0;
    n_cmp++; if (bus.issueValid !== 1'b1 || bus.issueOpcode !== 4'h2 || bus.issueDest !== 4'h4 ||
                 bus.issueA !== 16'h0055 || bus.issueB !== 16'h0066 || bus.stallCount !== 16'h0) begin
      n_fail++; $display("FAIL rms_issue got=v%0h op%0h rd%0h A%0h B%0h stall%0h exp=v1 op2 rd4 A55 B66 stall0",
                         bus.issueValid, bus.issueOpcode, bus.issueDest, bus.issueA, bus.issueB, bus.stallCount); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_issue();
    test_raw();
    test_backpressure();
    test_non_writing();
    test_set_wins();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
